// File: rtl/rr_arbiter_lock_pkg.sv
// Shared definitions for the locking round-robin arbiter:
// FSM state encoding, parameter-sizing helper and a one-hot encoder.
package rr_arbiter_lock_pkg;

    // Arbiter FSM: IDLE (no grant outstanding) or LOCKED (a packet owns the output).
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Widest one-hot vector the encoder below accepts.
    localparam int OH_MAX = 32;

    // Ceiling log2, used for default index widths (returns 0 for values <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One-hot to binary index. ORing the indices of all set bits keeps this a
    // flat OR tree; the input is guaranteed one-hot (or zero) by the callers.
    function automatic int unsigned oh_to_idx(input logic [0:OH_MAX-1] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < OH_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_fpa_lowfirst.sv
// Combinational fixed-priority select: returns the lowest set request index
// as a one-hot vector, or all zeros when nothing requests.
module rr_fpa_lowfirst #(
    parameter int N_REQ = 5
) (
    input  logic [0:N_REQ-1] req,
    output logic [0:N_REQ-1] gnt
);

    // Walk from index 0 upward and keep only the first request seen.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_lock.sv
// Registered round-robin arbiter with packet lock.
// A winner keeps the output until its tail flit is accepted downstream, then
// the arbiter re-arbitrates in that same cycle (no bubble between packets).
// Optional macro RR_ARB_IDX_EN adds the registered grant_idx_o port.
module rr_arbiter_lock
    import rr_arbiter_lock_pkg::*;
#(
    parameter int N_REQ   = 5,
    parameter int N_REQ_w = clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [0:N_REQ-1]   req_i,
    input  logic [0:N_REQ-1]   tail_i,
    input  logic               advance_i,
    output logic [0:N_REQ-1]   grant_o,
    output logic               grant_valid_o
`ifdef RR_ARB_IDX_EN
    ,
    output logic [N_REQ_w-1:0] grant_idx_o
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_reg, state_next;
    logic [N_REQ_w-1:0]   ptr_reg, ptr_next;
    logic [0:N_REQ-1]     grant_reg, grant_next;
    logic                 valid_reg, valid_next;
`ifdef RR_ARB_IDX_EN
    logic [N_REQ_w-1:0]   idx_reg, idx_next;
`endif

    // ------------------------------------------------------------------
    // Round-robin winner
    // ------------------------------------------------------------------
    logic [0:N_REQ-1]     ptr_mask;
    logic [0:N_REQ-1]     req_masked;
    logic [0:N_REQ-1]     masked_oh;
    logic [0:N_REQ-1]     unmasked_oh;
    logic [0:N_REQ-1]     winner_oh;
    logic [0:OH_MAX-1]    winner_pad;
    logic [N_REQ_w-1:0]   winner_idx;
    logic                 winner_any;
    logic                 masked_any;
    logic                 tail_hit;
    logic                 rearb;

    // Priority window: indices at or above the pointer are considered first.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign ptr_mask[gi] = (N_REQ_w'(gi) >= ptr_reg);
    end

    assign req_masked = req_i & ptr_mask;

    rr_fpa_lowfirst #(
        .N_REQ (N_REQ)
    ) u_fpa_masked (
        .req (req_masked),
        .gnt (masked_oh)
    );

    rr_fpa_lowfirst #(
        .N_REQ (N_REQ)
    ) u_fpa_unmasked (
        .req (req_i),
        .gnt (unmasked_oh)
    );

    // Nothing at/above the pointer means the search wraps to the lowest index.
    assign masked_any = |masked_oh;
    assign winner_oh  = masked_any ? masked_oh : unmasked_oh;
    assign winner_any = |winner_oh;

    // Zero-extend the winner to the encoder's fixed width.
    for (genvar gi = 0; gi < OH_MAX; gi++) begin : g_pad
        if (gi < N_REQ) begin : g_live
            assign winner_pad[gi] = winner_oh[gi];
        end else begin : g_zero
            assign winner_pad[gi] = 1'b0;
        end
    end

    assign winner_idx = N_REQ_w'(oh_to_idx(winner_pad));

    // Only the tail bit of the current owner matters.
    assign tail_hit = |(tail_i & grant_reg);

    // ------------------------------------------------------------------
    // Next-state logic: arbitrate when idle, or when the owner's tail leaves
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        valid_next = valid_reg;
`ifdef RR_ARB_IDX_EN
        idx_next   = idx_reg;
`endif
        rearb      = 1'b0;

        case (state_reg)
            ST_IDLE:   rearb = 1'b1;
            ST_LOCKED: rearb = advance_i && tail_hit;
            default:   rearb = 1'b1;
        endcase

        if (rearb) begin
            if (winner_any) begin
                // The pointer already sits one past the old owner, so the
                // releasing requester gets lowest priority this round.
                state_next = ST_LOCKED;
                grant_next = winner_oh;
                valid_next = 1'b1;
                ptr_next   = (winner_idx == N_REQ_w'(N_REQ - 1)) ?
                             '0 : winner_idx + 1'b1;
`ifdef RR_ARB_IDX_EN
                idx_next   = winner_idx;
`endif
            end else begin
                state_next = ST_IDLE;
                grant_next = '0;
                valid_next = 1'b0;
            end
        end
    end

    // State register; reset overrides everything, including an open packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            grant_reg <= '0;
            valid_reg <= 1'b0;
`ifdef RR_ARB_IDX_EN
            idx_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            valid_reg <= valid_next;
`ifdef RR_ARB_IDX_EN
            idx_reg   <= idx_next;
`endif
        end
    end

    assign grant_o       = grant_reg;
    assign grant_valid_o = valid_reg;
`ifdef RR_ARB_IDX_EN
    assign grant_idx_o   = idx_reg;
`endif

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Bench for rr_arbiter_lock: a directed vector table followed by a randomized
// phase checked against a behavioural rotation-search model.
module tb_rr_arbiter_lock;

    localparam int N = 5;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:N-1] req;
    logic [0:N-1] tail;
    logic         adv;
    logic [0:N-1] grant;
    logic         valid;
`ifdef RR_ARB_IDX_EN
    logic [W-1:0] gidx;
`endif

    always #5 clk = ~clk;

    rr_arbiter_lock #(
        .N_REQ   (N),
        .N_REQ_w (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .tail_i        (tail),
        .advance_i     (adv),
        .grant_o       (grant),
        .grant_valid_o (valid)
`ifdef RR_ARB_IDX_EN
        ,
        .grant_idx_o   (gidx)
`endif
    );

    typedef struct {
        logic         rst;
        logic [0:N-1] req;
        logic [0:N-1] tail;
        logic         adv;
        logic [0:N-1] exp;
    } vec_t;

    typedef struct {
        logic [0:N-1] grant;
        logic [W-1:0] idx;
        int           tag;
    } exp_t;

    vec_t         vecs[$];
    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] last_idx = '0;

    function automatic void add(input logic r, input logic [0:N-1] rq,
                                input logic [0:N-1] tl, input logic a,
                                input logic [0:N-1] e);
        vec_t v;
        v.rst = r; v.req = rq; v.tail = tl; v.adv = a; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic logic [W-1:0] idx_of(input logic [0:N-1] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return W'(i);
        end
        return '0;
    endfunction

    task automatic check();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard empty at time %0t", $time);
            return;
        end
        e = sb.pop_front();
        if (grant !== e.grant) begin
            bad++;
            $display("FAIL grant tag=%0d got=%b want=%b", e.tag, grant, e.grant);
        end
        total++;
        if (valid !== (e.grant != '0)) begin
            bad++;
            $display("FAIL valid tag=%0d got=%b want=%b", e.tag, valid, (e.grant != '0));
        end
        total++;
        if (!$onehot0(grant)) begin
            bad++;
            $display("FAIL onehot tag=%0d got=%b want=at most one bit", e.tag, grant);
        end
`ifdef RR_ARB_IDX_EN
        total++;
        if (gidx !== e.idx) begin
            bad++;
            $display("FAIL idx tag=%0d got=%0d want=%0d", e.tag, gidx, e.idx);
        end
`endif
        $display("txn tag=%0d rst=%b req=%b tail=%b adv=%b grant=%b valid=%b",
                 e.tag, rst, req, tail, adv, grant, valid);
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic apply(input logic r, input logic [0:N-1] rq,
                         input logic [0:N-1] tl, input logic a,
                         input logic [0:N-1] e, input int tag);
        exp_t x;
        rst  = r;
        req  = rq;
        tail = tl;
        adv  = a;
        if (r) last_idx = '0;
        else if (e != '0) last_idx = idx_of(e);
        x.grant = e;
        x.idx   = last_idx;
        x.tag   = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check();
    endtask

    // Model state for the randomized phase.
    logic         m_locked;
    int           m_ptr;
    int           m_g;

    initial begin
        logic [0:N-1] r, t, e;
        logic         a, rs, found;

        rst = 1'b1; req = '0; tail = '0; adv = 1'b0;

        // Reset with everyone requesting, then first grant to index 0.
        add(1, 5'b11111, 5'b00000, 0, 5'b00000);
        add(1, 5'b11111, 5'b00000, 0, 5'b00000);
        add(0, 5'b11111, 5'b00000, 0, 5'b10000);
        // Fairness: single-flit packets from everyone, 1,2,3,4,0,1.
        add(0, 5'b11111, 5'b11111, 1, 5'b01000);
        add(0, 5'b11111, 5'b11111, 1, 5'b00100);
        add(0, 5'b11111, 5'b11111, 1, 5'b00010);
        add(0, 5'b11111, 5'b11111, 1, 5'b00001);
        add(0, 5'b11111, 5'b11111, 1, 5'b10000);
        add(0, 5'b11111, 5'b11111, 1, 5'b01000);
        // Lock: 2 wins, 4-flit packet with 0 waiting, then 0.
        add(0, 5'b10100, 5'b11111, 1, 5'b00100);
        add(0, 5'b10100, 5'b00000, 1, 5'b00100);
        add(0, 5'b10100, 5'b00000, 1, 5'b00100);
        add(0, 5'b10100, 5'b00000, 1, 5'b00100);
        add(0, 5'b10100, 5'b00100, 1, 5'b10000);
        // Wrap and stall: grant 3, then 4 (ptr wraps), stall 3, then 1.
        add(0, 5'b00010, 5'b10000, 1, 5'b00010);
        add(0, 5'b01001, 5'b00010, 1, 5'b00001);
        add(0, 5'b01001, 5'b11111, 0, 5'b00001);
        add(0, 5'b01001, 5'b11111, 0, 5'b00001);
        add(0, 5'b01001, 5'b11111, 0, 5'b00001);
        add(0, 5'b01001, 5'b00001, 1, 5'b01000);
        // Owner drops its request mid-packet: held until tail+advance.
        add(0, 5'b00000, 5'b00000, 1, 5'b01000);
        add(0, 5'b00000, 5'b00000, 0, 5'b01000);
        add(0, 5'b00000, 5'b01000, 1, 5'b00000);
        // Advance pulses while idle change nothing; ptr still 2.
        add(0, 5'b00000, 5'b11111, 1, 5'b00000);
        add(0, 5'b00000, 5'b11111, 1, 5'b00000);
        add(0, 5'b11111, 5'b00000, 0, 5'b00100);
        // Reset mid-packet while locked on 3, then {1,3} -> 1.
        add(0, 5'b00010, 5'b00100, 1, 5'b00010);
        add(0, 5'b00010, 5'b00000, 1, 5'b00010);
        add(1, 5'b00010, 5'b00010, 1, 5'b00000);
        add(0, 5'b01010, 5'b00000, 0, 5'b01000);
        // Single-flit packets back to back, then idle.
        add(0, 5'b00011, 5'b01000, 1, 5'b00010);
        add(0, 5'b00001, 5'b00010, 1, 5'b00001);
        add(0, 5'b00000, 5'b00001, 1, 5'b00000);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].req, vecs[i].tail, vecs[i].adv, vecs[i].exp, i);
        end

        // Randomized phase: arbiter is idle with ptr=0 after the table.
        m_locked = 1'b0;
        m_ptr    = 0;
        m_g      = 0;
        for (int c = 0; c < 400; c++) begin
            r  = N'($urandom_range(0, (1 << N) - 1));
            t  = N'($urandom_range(0, (1 << N) - 1));
            a  = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 49) == 0);
            if (rs) begin
                m_locked = 1'b0;
                m_ptr    = 0;
            end else if (!m_locked || (a && t[m_g])) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!found && r[j]) begin
                        found = 1'b1;
                        m_g   = j;
                    end
                end
                m_locked = found;
                if (found) m_ptr = (m_g + 1) % N;
            end
            e = '0;
            if (m_locked) e[m_g] = 1'b1;
            apply(rs, r, t, a, e, 1000 + c);
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard leftover got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
